lcd_char_receiver: RTL and testbench

LCD_CHAR_RECEIVER -- requirements
Module: lcd_char_receiver

---
 rtl/lcd_char_receiver.sv | 197 +++++++++++++++++++
 tb/tb_lcd_char_receiver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_receiver.sv
// HD44780-style character LCD receiver: synchronizes the initiator bus and decodes writes into a 2x16 DDRAM.
// Define LCD_RX_READ_EN to enable the bus read-back path (busy/AC and DDRAM reads).

module lcd_char_receiver #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1640
) (
    input  logic       clk_LCD,
    input  logic       rst,
    input  logic       LCD_EN,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DB8,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       overrun,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       cmd_strobe
);

    localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [7:0] BLANK = 8'h20;

    logic [1:0]       en_sync, rs_sync, rw_sync;
    logic [7:0]       db_meta, db_sync;
    logic             en_d;
    logic             en_s, rs_s, rw_s;
    logic             fall, wr_txn, wr_accept, wr_reject, rd_accept;
    logic             is_nop, is_clear, is_long, data_store;
    logic             set_func, set_entry;
    logic [CNT_W-1:0] busy_cnt;
    logic [6:0]       ac;
    logic             id;
    logic             cgram_mode;
    logic [2:0]       func_cfg;
    logic             entry_shift;
    logic [7:0]       ddram [32];

    // AC moves through the two 40-cell line windows; anything outside them is plain 7-bit wrap.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic ac_visible(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] ac_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    assign en_s = en_sync[1];
    assign rs_s = rs_sync[1];
    assign rw_s = rw_sync[1];

    assign fall      = en_d & ~en_s;
    assign wr_txn    = fall & ~rw_s;
    assign wr_accept = wr_txn & ~busy;
    assign wr_reject = wr_txn & busy;

`ifdef LCD_RX_READ_EN
    assign rd_accept = fall & rw_s;
`else
    assign rd_accept = 1'b0;
`endif

    assign is_nop     = ~rs_s & (db_sync == 8'h00);
    assign is_clear   = ~rs_s & (db_sync == 8'h01);
    assign is_long    = ~rs_s & (db_sync[7:2] == 6'd0) & (db_sync[1:0] != 2'd0);
    assign data_store = wr_accept & rs_s & ~cgram_mode & ac_visible(ac);
    assign set_func   = wr_accept & ~rs_s & (db_sync[7:5] == 3'b001);
    assign set_entry  = wr_accept & ~rs_s & (db_sync[7:2] == 6'b000001);

    always_ff @(posedge clk_LCD) begin
        if (!rst) begin
            en_sync    <= '0;
            rs_sync    <= '0;
            rw_sync    <= '0;
            db_meta    <= '0;
            db_sync    <= '0;
            en_d       <= 1'b0;
            cmd_strobe <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            busy_cnt   <= '0;
            ac         <= '0;
            id         <= 1'b1;
            cgram_mode <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
        end else begin
            en_sync    <= {en_sync[0], LCD_EN};
            rs_sync    <= {rs_sync[0], RS};
            rw_sync    <= {rw_sync[0], RW};
            db_meta    <= DB8;
            db_sync    <= db_meta;
            en_d       <= en_s;
            cmd_strobe <= wr_accept | rd_accept;

            if (wr_reject)
                overrun <= 1'b1;

            if (busy) begin
                if (busy_cnt == '0) busy <= 1'b0;
                else                busy_cnt <= busy_cnt - CNT_W'(1);
            end
            if (wr_accept && !is_nop) begin
                busy     <= 1'b1;
                busy_cnt <= is_long ? CLEAR_LOAD : BUSY_LOAD;
            end

            if (wr_accept && rs_s) begin
                if (!cgram_mode)
                    ac <= ac_step(ac, id);
            end else if (wr_accept) begin
                casez (db_sync)
                    8'b1???????: begin
                        ac         <= db_sync[6:0];
                        cgram_mode <= 1'b0;
                    end
                    8'b01??????: cgram_mode <= 1'b1;
                    8'b0001????: if (!db_sync[3]) ac <= ac_step(ac, db_sync[2]);
                    8'b00001???: begin
                        disp_on   <= db_sync[2];
                        cursor_on <= db_sync[1];
                        blink_on  <= db_sync[0];
                    end
                    8'b000001??: id <= db_sync[1];
                    8'b0000001?: ac <= '0;
                    8'b00000001: begin
                        ac <= '0;
                        id <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (rd_accept && rs_s)
                ac <= ac_step(ac, id);
        end
    end

    // DL/N/F and the entry-mode shift bit are retained only; nothing here acts on them.
    always_ff @(posedge clk_LCD) begin
        if (!rst) begin
            func_cfg    <= '0;
            entry_shift <= 1'b0;
        end else begin
            func_cfg    <= set_func ? db_sync[4:2] : func_cfg;
            entry_shift <= set_entry ? db_sync[0] : entry_shift;
        end
    end

    always_ff @(posedge clk_LCD) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) ddram[i] <= BLANK;
            rd_char <= 8'h00;
        end else begin
            rd_char <= ddram[rd_addr];
            if (wr_accept && is_clear) begin
                for (int i = 0; i < 32; i++) ddram[i] <= BLANK;
            end else if (data_store) begin
                ddram[ac_index(ac)] <= db_sync;
            end
        end
    end

`ifdef LCD_RX_READ_EN
    logic [7:0] rd_data;
    assign rd_data = ac_visible(ac) ? ddram[ac_index(ac)] : BLANK;
    assign DB_OE   = en_s & rw_s;
    assign DB_OUT  = !DB_OE ? 8'h00 : (rs_s ? rd_data : {busy, ac});
`else
    assign DB_OE  = 1'b0;
    assign DB_OUT = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Bench for lcd_char_receiver: directed scenarios plus random traffic against a rule-level model.
// Honors LCD_RX_READ_EN the same way the design does.

module tb_lcd_char_receiver;

    localparam int BUSY_N = 40;
    localparam int CLR_N  = 1640;

    logic       clk_LCD = 1'b0;
    logic       rst     = 1'b0;
    logic       LCD_EN  = 1'b0;
    logic       RS      = 1'b0;
    logic       RW      = 1'b0;
    logic [7:0] DB8     = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] DB_OUT, rd_char;
    logic       DB_OE, busy, overrun, disp_on, cursor_on, blink_on, cmd_strobe;

    lcd_char_receiver #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLR_N)) dut (
        .clk_LCD(clk_LCD), .rst(rst), .LCD_EN(LCD_EN), .RS(RS), .RW(RW), .DB8(DB8),
        .DB_OUT(DB_OUT), .DB_OE(DB_OE), .rd_addr(rd_addr), .rd_char(rd_char),
        .busy(busy), .overrun(overrun), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .cmd_strobe(cmd_strobe)
    );

    always #5 clk_LCD = ~clk_LCD;

    int total = 0;
    int bad   = 0;
    int busy_seen   = 0;
    int strobe_seen = 0;

    always @(negedge clk_LCD) begin
        if (busy === 1'b1)       busy_seen++;
        if (cmd_strobe === 1'b1) strobe_seen++;
    end

    logic [7:0] m_mem [32];
    int m_ac;
    bit m_id, m_cg, m_disp, m_cur, m_blk, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1; m_cg = 0;
        m_disp = 0; m_cur = 0; m_blk = 0; m_ovr = 0;
    endtask

    function automatic int m_adv(input int a, input bit up);
        if (up) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return (a + 127) % 128;
    endfunction

    function automatic bit m_vis(input int a);
        return (a < 16) || (a >= 64 && a < 80);
    endfunction

    function automatic int m_idx(input int a);
        return (a < 16) ? a : a - 48;
    endfunction

    // Applies one accepted write to the model; returns the expected busy length.
    function automatic int mdl_write(input bit rs, input logic [7:0] db);
        if (rs) begin
            if (!m_cg) begin
                if (m_vis(m_ac)) m_mem[m_idx(m_ac)] = db;
                m_ac = m_adv(m_ac, m_id);
            end
            return BUSY_N;
        end
        if (db == 8'h00) return 0;
        if (db >= 8'h80) begin
            m_ac = int'(db) - 128;
            m_cg = 0;
        end else if (db >= 8'h40) begin
            m_cg = 1;
        end else if (db >= 8'h20) begin
        end else if (db >= 8'h10) begin
            if (db[3] == 1'b0) m_ac = m_adv(m_ac, db[2]);
        end else if (db >= 8'h08) begin
            m_disp = db[2]; m_cur = db[1]; m_blk = db[0];
        end else if (db >= 8'h04) begin
            m_id = db[1];
        end else if (db >= 8'h02) begin
            m_ac = 0;
            return CLR_N;
        end else begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_ac = 0; m_id = 1;
            return CLR_N;
        end
        return BUSY_N;
    endfunction

    task automatic send(input bit rs, input bit rw, input logic [7:0] db);
        @(negedge clk_LCD);
        RS = rs; RW = rw; DB8 = db; LCD_EN = 1'b1;
        repeat (4) @(negedge clk_LCD);
        LCD_EN = 1'b0;
        repeat (4) @(negedge clk_LCD);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy === 1'b1 && g < 3000) begin
            @(negedge clk_LCD);
            g++;
        end
        check("idle_timeout", (g < 3000), 1);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_disp"},  disp_on,   m_disp);
        check({tag, "_cur"},   cursor_on, m_cur);
        check({tag, "_blink"}, blink_on,  m_blk);
        check({tag, "_ovr"},   overrun,   m_ovr);
    endtask

    task automatic check_cells(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_LCD);
            rd_addr = 5'(i);
            @(negedge clk_LCD);
            check($sformatf("%s_cell%0d", tag, i), rd_char, m_mem[i]);
        end
    endtask

    // One write; with dbl set, a second write follows while still busy and must be dropped.
    task automatic xact(input bit rs, input logic [7:0] db, input bit dbl);
        int b0, s0, exp_b;
        b0 = busy_seen; s0 = strobe_seen;
        exp_b = mdl_write(rs, db);
        send(rs, 1'b0, db);
        if (dbl && exp_b > 0) begin
            send(1'b1, 1'b0, 8'h5A);
            m_ovr = 1;
        end
        wait_idle();
        check($sformatf("busy_len_%0h", db), busy_seen - b0, exp_b);
        check($sformatf("strobe_%0h", db), strobe_seen - s0, 1);
        check_flags("xact");
    endtask

    task automatic do_read(input bit rs, input bit busy_now);
        int s0;
        bit exp_oe;
        logic [7:0] exp_out;
        s0 = strobe_seen;
`ifdef LCD_RX_READ_EN
        exp_oe  = 1;
        exp_out = rs ? (m_vis(m_ac) ? m_mem[m_idx(m_ac)] : 8'h20) : {busy_now, 7'(m_ac)};
`else
        exp_oe  = 0;
        exp_out = 8'h00;
`endif
        @(negedge clk_LCD);
        RS = rs; RW = 1'b1; DB8 = 8'($urandom); LCD_EN = 1'b1;
        repeat (4) @(negedge clk_LCD);
        check("rd_oe", DB_OE, exp_oe);
        check("rd_out", DB_OUT, exp_out);
        LCD_EN = 1'b0;
        repeat (4) @(negedge clk_LCD);
        RW = 1'b0;
`ifdef LCD_RX_READ_EN
        if (rs) m_ac = m_adv(m_ac, m_id);
        check("rd_strobe", strobe_seen - s0, 1);
`else
        check("rd_strobe", strobe_seen - s0, 0);
`endif
        check_flags("rd");
    endtask

    initial begin
        string s1, s2;
        logic [7:0] db;
        int r, s0;
        s1 = "Embedded System!";
        s2 = "Made By Kun Hua.";
        model_reset();

        repeat (5) @(negedge clk_LCD);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_strobe", cmd_strobe, 0);
        check("rst_oe", DB_OE, 0);
        check("rst_out", DB_OUT, 8'h00);
        check("rst_rdchar", rd_char, 8'h00);
        check_flags("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk_LCD);

        xact(0, 8'h38, 0);
        xact(0, 8'h0C, 0);
        xact(0, 8'h06, 0);
        xact(0, 8'h80, 0);
        for (int i = 0; i < s1.len(); i++) xact(1, s1[i], 0);
        check("line0_disp", disp_on, 1);
        check("line0_cur", cursor_on, 0);
        check_cells("line0");

        xact(0, 8'hC0, 0);
        for (int i = 0; i < s2.len(); i++) xact(1, s2[i], 0);
        check_cells("line1");
        xact(0, 8'h01, 0);
        check_cells("clear");

        xact(0, 8'h80, 1);
        check("overrun_set", overrun, 1);
        check_cells("overrun");

        xact(0, 8'hA7, 0);
        xact(1, "X", 0);
        check_cells("hidden");
        xact(0, 8'h80, 0);
        xact(0, 8'h04, 0);
        xact(1, "Y", 0);
        xact(0, 8'h06, 0);
        xact(1, "Z", 0);
        xact(1, "W", 0);
        check_cells("wrap");

        s0 = strobe_seen;
        send(0, 1'b0, 8'h85);
        r = mdl_write(0, 8'h85);
        do_read(0, 1'b1);
        wait_idle();
        do_read(0, 1'b0);
        do_read(1, 1'b0);

        for (int k = 0; k < 70; k++) begin
            r = $urandom_range(0, 15);
            if (r < 6) begin
                xact(1, 8'($urandom_range(32, 126)), ($urandom_range(0, 7) == 0));
            end else if (r < 8) begin
                do_read(1'($urandom_range(0, 1)), 1'b0);
            end else if (r < 11) begin
                db = 8'h80 | 8'($urandom_range(0, 1) << 6) | 8'($urandom_range(0, 18));
                xact(0, db, ($urandom_range(0, 7) == 0));
            end else begin
                db = 8'($urandom);
                if (db[7:2] == 6'd0 && db != 8'h00 && $urandom_range(0, 3) != 0) db = db | 8'h08;
                xact(0, db, ($urandom_range(0, 7) == 0));
            end
        end
        check_cells("random");

        xact(0, 8'h80, 0);
        send(1, 1'b0, "Q");
        @(negedge clk_LCD);
        rst = 1'b0;
        @(negedge clk_LCD);
        check("midbusy_busy", busy, 0);
        check("midbusy_strobe", cmd_strobe, 0);
        rst = 1'b1;
        model_reset();
        check_flags("midbusy");
        check_cells("midbusy");

        s0 = strobe_seen;
        @(negedge clk_LCD);
        RS = 1'b1; RW = 1'b0; DB8 = "R"; LCD_EN = 1'b1;
        repeat (4) @(negedge clk_LCD);
        LCD_EN = 1'b0;
        @(negedge clk_LCD);
        rst = 1'b0;
        repeat (3) @(negedge clk_LCD);
        rst = 1'b1;
        repeat (6) @(negedge clk_LCD);
        check("pend_strobe", strobe_seen - s0, 0);
        check("pend_busy", busy, 0);
        check_cells("pending");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
